// File: rtl/bus_arbiter_mem.sv
// bus_arbiter_mem: round-robin shared-bus arbiter serving the granted PE from an on-chip word array.
// Optional idle-grant watchdog is compiled in by defining ARB_TIMEOUT_EN.
module bus_arbiter_mem #(
  parameter int NUM_PE         = 4,
  parameter int DEPTH          = 256,
  parameter int MEM_LATENCY    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PE-1:0] bus_request,
  output logic [NUM_PE-1:0] grant,
  input  logic              mem_readBus,
  input  logic              mem_writeBus,
  input  logic [31:0]       mem_addressBus,
  input  logic [31:0]       result_outBus,
  output logic              mem_ackBus,
  output logic [31:0]       memData,
  output logic              arb_timeout
);
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, GRANTED, ACCESS, ACK, DRAIN} state_t;

  typedef struct packed {
    logic        wr;
    logic [29:0] word;
    logic [31:0] data;
  } accReq_t;

  state_t            state, stateNext;
  logic [PW-1:0]     owner, ownerNext, last, lastNext, winner;
  logic              anyReq;
  logic [CW-1:0]     latCnt, latCntNext;
  accReq_t           acc, accNext;
  logic [NUM_PE-1:0] grantNext;
  logic              ackNext, doAccess, inRange;
  logic [1:0]        unusedAddrBits;
  logic [31:0]       mem [DEPTH];

  assign unusedAddrBits = mem_addressBus[1:0];

  // Search upward from last+1, wrapping at NUM_PE; first set request wins.
  always_comb begin
    logic [PW:0] cand;
    winner = '0;
    anyReq = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_PE; k++) begin
      cand = {1'b0, last} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_PE)) cand = cand - (PW+1)'(NUM_PE);
      if (!anyReq && bus_request[cand[PW-1:0]]) begin
        anyReq = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] idleCnt, idleCntNext;
  logic          toNext;
`else
  localparam int unusedTimeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    stateNext  = state;
    ownerNext  = owner;
    lastNext   = last;
    latCntNext = latCnt;
    accNext    = acc;
    grantNext  = grant;
    ackNext    = 1'b0;
    doAccess   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    idleCntNext = idleCnt;
    toNext      = 1'b0;
`endif
    case (state)
      IDLE: begin
        grantNext = '0;
        if (anyReq) begin
          stateNext         = GRANTED;
          ownerNext         = winner;
          grantNext[winner] = 1'b1;
`ifdef ARB_TIMEOUT_EN
          idleCntNext = '0;
`endif
        end
      end
      GRANTED: begin
        if (mem_writeBus || mem_readBus) begin
          accNext    = '{wr: mem_writeBus, word: mem_addressBus[31:2], data: result_outBus};
          latCntNext = CW'(MEM_LATENCY - 1);
          stateNext  = ACCESS;
        end else if (!bus_request[owner]) begin
          grantNext = '0;
          lastNext  = owner;
          stateNext = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (idleCnt == TW'(TIMEOUT_CYCLES - 1)) begin
          grantNext = '0;
          lastNext  = owner;
          toNext    = 1'b1;
          stateNext = IDLE;
        end else begin
          idleCntNext = idleCnt + 1'b1;
        end
`endif
      end
      ACCESS: begin
        if (latCnt == '0) begin
          doAccess  = 1'b1;
          ackNext   = 1'b1;
          stateNext = ACK;
        end else begin
          latCntNext = latCnt - 1'b1;
        end
      end
      ACK: stateNext = DRAIN;
      // A strobe still held from the finished access must not start another one.
      DRAIN: begin
        if (!mem_readBus && !mem_writeBus) begin
          stateNext = GRANTED;
`ifdef ARB_TIMEOUT_EN
          idleCntNext = '0;
`endif
        end
      end
      default: begin
        stateNext = IDLE;
        grantNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last       <= PW'(NUM_PE - 1);
      latCnt     <= '0;
      acc        <= '0;
      grant      <= '0;
      mem_ackBus <= 1'b0;
    end else begin
      state      <= stateNext;
      owner      <= ownerNext;
      last       <= lastNext;
      latCnt     <= latCntNext;
      acc        <= accNext;
      grant      <= grantNext;
      mem_ackBus <= ackNext;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idleCnt     <= '0;
      arb_timeout <= 1'b0;
    end else begin
      idleCnt     <= idleCntNext;
      arb_timeout <= toNext;
    end
  end
`else
  assign arb_timeout = 1'b0;
`endif

  // Any nonzero bit above the array index puts the word index at or beyond DEPTH.
  assign inRange = (acc.word[29:AW] == '0);

  always_ff @(posedge clk) begin
    if (doAccess && acc.wr && inRange) mem[acc.word[AW-1:0]] <= acc.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) memData <= '0;
    else if (doAccess && !acc.wr) memData <= inRange ? mem[acc.word[AW-1:0]] : '0;
  end
endmodule
